// File: rtl/spi_resp_pkg.sv
// Shared opcodes, field widths and FSM encoding for the SPI memory responder.
// The STATUS opcode is only treated as known when SPI_RESP_STATUS_EN is defined.
package spi_resp_pkg;

  localparam int CMD_W        = 8;
  localparam int ADDR_FIELD_W = 24;
  localparam int DATA_W       = 32;

  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_STATUS  = 8'h05;
  localparam logic [7:0] STATUS_SIG = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_DROP
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
`ifdef SPI_RESP_STATUS_EN
    return (op == OP_WRITE) || (op == OP_READ) || (op == OP_STATUS);
`else
    return (op == OP_WRITE) || (op == OP_READ);
`endif
  endfunction

endpackage

// File: rtl/spi_mem_responder_if.sv
// Serial link between the SPI master and the memory responder, plus the
// responder's status outputs.
interface spi_mem_responder_if;
  logic cs;
  logic sck;
  logic mosi;
  logic miso;
  logic busy;
  logic cmd_err;

  modport master (output cs, sck, mosi, input miso, busy, cmd_err);
  modport slave  (input cs, sck, mosi, output miso, busy, cmd_err);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus a delay flop giving
// single-cycle rise/fall strobes aligned with the synchronised level.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target: 8-bit command, 24-bit address, 32-bit data into a
// register word memory. SPI_RESP_STATUS_EN adds the STATUS opcode and counters.
//
// state  | meaning
// IDLE   | waiting for cs fall
// CMD    | shifting in the 8 opcode bits
// ADDR   | shifting in the 24 address bits
// WDATA  | shifting in write data, commit on the 32nd bit
// RDATA  | shifting out the latched read word on sck falls
// DROP   | unknown opcode, ignore sck until cs rises
module spi_mem_responder
  import spi_resp_pkg::*;
#(
  parameter int MEM_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  spi_mem_responder_if.slave spi
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_rise, sck_fall, mosi_lvl;
  logic sck_level_unused, mosi_rise_unused, mosi_fall_unused;
  logic bit_rise, bit_fall;

  state_e state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] sh_in;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ok_q, ok_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W-1:0] addr_idx;
  logic              addr_ok;
  logic              mem_we, field_err;
  logic              miso_q, miso_d, busy_q, busy_d, cmd_err_q, cmd_err_d;

  spi_sync_edge u_cs   (.clk(clk), .rst(rst), .d_i(spi.cs),   .level(cs_lvl),
                        .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge u_sck  (.clk(clk), .rst(rst), .d_i(spi.sck),  .level(sck_level_unused),
                        .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge u_mosi (.clk(clk), .rst(rst), .d_i(spi.mosi), .level(mosi_lvl),
                        .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  // sck edges only count while the frame is selected
  assign bit_rise = sck_rise & ~cs_lvl;
  assign bit_fall = sck_fall & ~cs_lvl;

  assign sh_in    = {rx_q, mosi_lvl};
  assign addr_idx = sh_in[ADDR_W-1:0];
  assign addr_ok  = ~|sh_in[ADDR_FIELD_W-1:ADDR_W];
  assign rd_word  = addr_ok ? mem_q[addr_idx] : '0;

`ifdef SPI_RESP_STATUS_EN
  logic [15:0]       wr_cnt_q;
  logic [7:0]        err_cnt_q;
  logic [DATA_W-1:0] status_word;

  assign status_word = {wr_cnt_q, err_cnt_q, STATUS_SIG};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (mem_we) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (cmd_err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    op_d      = op_q;
    idx_d     = idx_q;
    ok_d      = ok_q;
    tx_d      = tx_q;
    mem_we    = 1'b0;
    field_err = 1'b0;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        ST_CMD: begin
          if (bit_rise) begin
            rx_d      = sh_in[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'(CMD_W - 1)) begin
              bit_cnt_d = '0;
              op_d      = sh_in[7:0];
              if (op_known(sh_in[7:0])) begin
                state_d = ST_ADDR;
              end else begin
                state_d   = ST_DROP;
                field_err = 1'b1;
              end
            end
          end
        end
        ST_ADDR: begin
          if (bit_rise) begin
            rx_d      = sh_in[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'(ADDR_FIELD_W - 1)) begin
              bit_cnt_d = '0;
              idx_d     = addr_idx;
              ok_d      = addr_ok;
              if (op_q == OP_WRITE) begin
                state_d   = ST_WDATA;
                field_err = ~addr_ok;
              end
`ifdef SPI_RESP_STATUS_EN
              else if (op_q == OP_STATUS) begin
                state_d = ST_RDATA;
                tx_d    = status_word;
              end
`endif
              else begin
                state_d   = ST_RDATA;
                tx_d      = rd_word;
                field_err = ~addr_ok;
              end
            end
          end
        end
        ST_WDATA: begin
          if (bit_rise) begin
            rx_d      = sh_in[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'(DATA_W - 1)) begin
              state_d = ST_IDLE;
              mem_we  = ok_q;
            end
          end
        end
        ST_RDATA: begin
          if (bit_rise) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'(DATA_W - 1)) state_d = ST_IDLE;
          end
          if (bit_fall) tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
        ST_DROP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // miso keeps the last bit after the frame completes until cs is released
  always_comb begin
    busy_d    = (state_q != ST_IDLE);
    cmd_err_d = field_err;
    miso_d    = miso_q;
    if (cs_rise)                                miso_d = 1'b0;
    else if ((state_q == ST_RDATA) && bit_fall) miso_d = tx_q[DATA_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      ok_q      <= 1'b0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      ok_q      <= ok_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx_q] <= sh_in;
    end
  end

  assign spi.miso    = miso_q;
  assign spi.busy    = busy_q;
  assign spi.cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed frames against spi_mem_responder; expectations are queued per frame
// and checked by a pin monitor when cs rises.
module tb_spi_mem_responder;

  localparam int HALF = 4;

  logic clk;
  logic rst;

  spi_mem_responder_if bus ();

  spi_mem_responder dut (
    .clk (clk),
    .rst (rst),
    .spi (bus)
  );

  typedef struct {
    logic [31:0] rd;
    bit          chk;
    int          errs;
  } exp_t;

  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  logic b3, b4, m2, m3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [23:0] addr,
                            input logic [31:0] wd, input int nbits,
                            input logic [31:0] exp_rd, input bit chk, input int errs);
    logic [63:0] f;
    exp_t e;
    f = {op, addr, wd};
    e.rd = exp_rd; e.chk = chk; e.errs = errs;
    sb.push_back(e);
    bus.mosi = f[63];
    bus.cs   = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = f[63-i];
      tick(HALF);
      bus.sck = 1'b1;
      tick(HALF);
      bus.sck = 1'b0;
    end
    tick(HALF);
    bus.cs = 1'b1;
    tick(2); m2 = bus.miso;
    tick(1); m3 = bus.miso; b3 = bus.busy;
    tick(1); b4 = bus.busy;
    bus.mosi = 1'b0;
    tick(6);
  endtask

  // pin monitor: one frame per cs low period, sampled mid-cycle
  initial begin
    int          rises, errs, fnum;
    logic [31:0] cap;
    logic        cs_prev, sck_prev;
    exp_t        e;
    rises = 0; errs = 0; fnum = 0; cap = '0;
    cs_prev = 1'b1; sck_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cs_prev === 1'b1 && bus.cs === 1'b0) begin
        rises = 0; errs = 0; cap = '0;
      end
      if (bus.cs === 1'b0 && bus.sck === 1'b1 && sck_prev === 1'b0) begin
        rises++;
        if (rises > 32 && rises <= 64) cap = {cap[30:0], bus.miso};
      end
      if (bus.cmd_err === 1'b1) errs++;
      if (cs_prev === 1'b0 && bus.cs === 1'b1) begin
        fnum++;
        if (sb.size() == 0) begin
          checks_total++;
          $display("FAIL sb_underflow: got frame %0d with no expectation, expected none", fnum);
        end else begin
          e = sb.pop_front();
          if (e.chk) check($sformatf("rdata#%0d", fnum), cap, e.rd);
          check($sformatf("cmd_err#%0d", fnum), 32'(errs), 32'(e.errs));
        end
      end
      cs_prev  = bus.cs;
      sck_prev = bus.sck;
    end
  end

  initial begin
    rst = 1'b1; bus.cs = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
    tick(3);
    check("rst_miso",    32'(bus.miso),    32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    rst = 1'b0;
    tick(4);

    send_frame(8'h02, 24'h000003, 32'hDEADBEEF, 64, 32'h0, 1, 0);
    send_frame(8'h03, 24'h000003, 32'h0,        64, 32'hDEADBEEF, 1, 0);
    check("rd_bit0_hold", 32'(m2), 32'd1);
    check("miso_release", 32'(m3), 32'd0);

    send_frame(8'h7E, 24'h000000, 32'hFFFFFFFF, 64, 32'h0, 1, 1);
    send_frame(8'h03, 24'h000000, 32'h0,        64, 32'h0, 1, 0);

    send_frame(8'h02, 24'h000001, 32'h13579BDF, 52, 32'h0, 0, 0);
    check("abort_busy_3clk", 32'(b3), 32'd1);
    check("abort_busy_4clk", 32'(b4), 32'd0);
    send_frame(8'h03, 24'h000001, 32'h0, 64, 32'h0, 1, 0);

    send_frame(8'h02, 24'h000100, 32'h12345678, 64, 32'h0, 1, 1);
    send_frame(8'h03, 24'h000100, 32'h0,        64, 32'h0, 1, 1);
    send_frame(8'h03, 24'h000000, 32'h0,        64, 32'h0, 1, 0);
    send_frame(8'h03, 24'h000003, 32'h0,        64, 32'hDEADBEEF, 1, 0);

    send_frame(8'h02, 24'h000002, 32'h11112222, 64, 32'h0, 1, 0);
    send_frame(8'h03, 24'h000002, 32'h0,        64, 32'h11112222, 1, 0);

    fork
      send_frame(8'h02, 24'h000002, 32'hCAFEF00D, 64, 32'h0, 1, 0);
      begin
        tick(HALF + 2 * HALF * 44);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_miso",    32'(bus.miso),    32'd0);
        check("mid_rst_busy",    32'(bus.busy),    32'd0);
        check("mid_rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        tick(2);
        rst = 1'b0;
      end
    join
    send_frame(8'h03, 24'h000002, 32'h0, 64, 32'h0, 1, 0);

    send_frame(8'h02, 24'h000004, 32'h00000001, 64, 32'h0, 1, 0);
    send_frame(8'h02, 24'h000006, 32'h00000002, 64, 32'h0, 1, 0);
    send_frame(8'hFF, 24'h000000, 32'h0,        64, 32'h0, 1, 1);
`ifdef SPI_RESP_STATUS_EN
    send_frame(8'h05, 24'h000000, 32'h0, 64, 32'h0002015A, 1, 0);
`else
    send_frame(8'h05, 24'h000000, 32'h0, 64, 32'h0, 1, 1);
`endif
    send_frame(8'h03, 24'h000006, 32'h0, 64, 32'h00000002, 1, 0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
